// File: rtl/xs3_pkg.sv
// Shared constants and FSM state type for the Excess-3 to BCD sequencer.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] BCD_INVALID = 4'hF;
  localparam logic [3:0] XS3_MIN     = 4'b0011;
  localparam logic [3:0] XS3_MAX     = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } xs3_seq_state_t;

endpackage

// File: rtl/xs3_digit_conv.sv
// Single-digit Excess-3 to BCD converter; out-of-range codes yield BCD_INVALID.
module xs3_digit_conv
  import xs3_pkg::*;
(
  input  logic [3:0] xs3,
  output logic [3:0] bcd,
  output logic       invalid
);

  always_comb begin
    invalid = (xs3 < XS3_MIN) || (xs3 > XS3_MAX);
    bcd     = invalid ? BCD_INVALID : (xs3 - XS3_OFFSET);
  end

endmodule

// File: rtl/xs3_bcd_seq.sv
// Multi-digit Excess-3 to BCD sequencer: one digit per clock, LSD first,
// through a single shared converter, with first-bad-digit capture.
module xs3_bcd_seq
  import xs3_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_xs3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic [IDXW-1:0]       out_err_idx
);

  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

  xs3_seq_state_t        state_q, state_d;
  logic [IDXW-1:0]       idx;
  logic [4*DIGITS-1:0]   hold;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  err_q;
  logic [IDXW-1:0]       err_idx_q;
  logic [3:0]            dig_bcd;
  logic                  dig_inv;

  // hold shifts right each CONV cycle, so the current digit is always hold[3:0]
  xs3_digit_conv u_conv (
    .xs3     (hold[3:0]),
    .bcd     (dig_bcd),
    .invalid (dig_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)    state_d = CONV;
      CONV:    if (idx == LAST) state_d = DONE;
      DONE:    if (out_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      idx       <= '0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          hold      <= in_xs3;
          bcd_q     <= '0;
          err_q     <= 1'b0;
          err_idx_q <= '0;
          idx       <= '0;
        end
        CONV: begin
          hold               <= hold >> 4;
          bcd_q[idx*4 +: 4]  <= dig_bcd;
          // lowest bad digit wins; later ones leave err_idx alone
          if (dig_inv && !err_q) begin
            err_q     <= 1'b1;
            err_idx_q <= idx;
          end
          if (idx != LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_bcd     = bcd_q;
  assign out_err     = err_q;
  assign out_err_idx = err_idx_q;

endmodule
